// File: rtl/ps2_mouse_packet_tx_if.sv
// rtl/ps2_mouse_packet_tx_if.sv - report handshake and PS/2 line signals for ps2_mouse_packet_tx
interface ps2_mouse_packet_tx_if;
  logic       report_valid;
  logic       report_ready;
  logic       left_button;
  logic       right_button;
  logic       middle_button;
  logic [9:0] delta_x;
  logic [9:0] delta_y;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       packet_sent;
  logic       byte_aborted;

  modport master (
    output report_valid, left_button, right_button, middle_button, delta_x, delta_y,
    output ps2_clk_in, ps2_dat_in,
    input  report_ready, busy, packet_sent, byte_aborted, ps2_clk_oe, ps2_dat_oe
  );

  modport slave (
    input  report_valid, left_button, right_button, middle_button, delta_x, delta_y,
    input  ps2_clk_in, ps2_dat_in,
    output report_ready, busy, packet_sent, byte_aborted, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_mouse_packet_tx.sv
// rtl/ps2_mouse_packet_tx.sv - device-side PS/2 mouse transmitter: one report in, three framed bytes out
// Open-drain drivers: *_oe=1 pulls the line low; host inhibit aborts and retries the current byte.
module ps2_mouse_packet_tx #(
  parameter int CLK_DIV    = 2000,
  parameter int GAP_CYCLES = 4000
) (
  input logic             CLOCK_50,
  input logic             reset,
  ps2_mouse_packet_tx_if.slave bus
);
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE   = CW'(3);

  typedef enum logic [2:0] {IDLE, WAIT_BUS, BIT_HIGH, BIT_LOW, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   pkt_q, pkt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          sent_q, sent_d;
  logic          abort_q, abort_d;
  logic          clk_meta_q, clk_s_q, dat_meta_q, dat_s_q;

  logic [9:0] sat_x, sat_y;
  logic [7:0] byte0, cur_byte;
  logic [3:0] next_bit;
  logic       lines_free;

  // {overflow, 9-bit clamped value}
  function automatic logic [9:0] saturate(input logic [9:0] d);
    if ($signed(d) > 10'sd255)       return {1'b1, 9'h0FF};
    else if ($signed(d) < -10'sd256) return {1'b1, 9'h100};
    else                             return {1'b0, d[8:0]};
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    case (idx)
      4'd0:    return 1'b0;
      4'd9:    return ~^b;
      4'd10:   return 1'b1;
      default: return b[3'(idx - 4'd1)];
    endcase
  endfunction

  assign sat_x      = saturate(bus.delta_x);
  assign sat_y      = saturate(bus.delta_y);
  assign byte0      = {sat_y[9], sat_x[9], sat_y[8], sat_x[8], 1'b1,
                       bus.middle_button, bus.right_button, bus.left_button};
  assign next_bit   = bit_q + 4'd1;
  assign lines_free = clk_s_q & dat_s_q;

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = pkt_q[7:0];
      2'd1:    cur_byte = pkt_q[15:8];
      default: cur_byte = pkt_q[23:16];
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_s_q    <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_s_q    <= 1'b1;
    end else begin
      clk_meta_q <= bus.ps2_clk_in;
      clk_s_q    <= clk_meta_q;
      dat_meta_q <= bus.ps2_dat_in;
      dat_s_q    <= dat_meta_q;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      pkt_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      sent_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      pkt_q    <= pkt_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      sent_q   <= sent_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    pkt_d    = pkt_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    sent_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.report_valid) begin
          pkt_d  = {sat_y[7:0], sat_x[7:0], byte0};
          byte_d = 2'd0;
          bit_d  = 4'd0;
          cnt_d  = '0;
          // A free bus at accept starts the start bit immediately.
          if (lines_free) begin
            state_d  = BIT_HIGH;
            dat_oe_d = 1'b1;
          end else begin
            state_d = WAIT_BUS;
          end
        end
      end
      WAIT_BUS: begin
        if (!lines_free) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d  = BIT_HIGH;
          cnt_d    = '0;
          bit_d    = 4'd0;
          dat_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BIT_HIGH: begin
        // Early cycles still see our own low clock through the synchroniser.
        if (bit_q <= 4'd9 && cnt_q >= SETTLE && !clk_s_q) begin
          state_d  = WAIT_BUS;
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          abort_d  = 1'b1;
        end else if (cnt_q == DIV_LAST) begin
          state_d  = BIT_LOW;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BIT_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          if (bit_q == 4'd10) begin
            state_d  = GAP;
            dat_oe_d = 1'b0;
          end else begin
            state_d  = BIT_HIGH;
            bit_d    = next_bit;
            dat_oe_d = ~frame_bit(cur_byte, next_bit);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (byte_q == 2'd2) begin
            state_d = IDLE;
            sent_d  = 1'b1;
          end else begin
            state_d  = BIT_HIGH;
            byte_d   = byte_q + 2'd1;
            bit_d    = 4'd0;
            dat_oe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.report_ready = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.ps2_clk_oe   = clk_oe_q;
  assign bus.ps2_dat_oe   = dat_oe_q;
  assign bus.packet_sent  = sent_q;
  assign bus.byte_aborted = abort_q;
endmodule

// File: doc/ps2_mouse_packet_tx.md
# ps2_mouse_packet_tx

Device-side PS/2 mouse transmitter: the opposite end of the mouse receive path (PS/2 controller plus mouse packet parser). It takes one movement report (buttons plus signed deltas), formats the standard 3-byte mouse packet, and serialises each byte as a PS/2 device-to-host frame on open-drain line drivers. Uses: hardware-in-loop stimulus for the paint datapath, and a board-to-board mouse emulator.

## Interface
- CLK_DIV, 2000: CLOCK_50 cycles per PS/2 clock half-period (12.5 kHz at 50 MHz); minimum 8.
- GAP_CYCLES, 4000: idle cycles after each stop bit; also the bus-free time required before retrying an aborted byte.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- report_valid  in  1  a report is offered.
- report_ready  out  1  high only in IDLE; a report is accepted when valid and ready are both high at a clock edge.
- left_button, right_button, middle_button  in  1 each  button states, sampled on accept.
- delta_x, delta_y  in  10 each  two's-complement movement (-512..511), sampled on accept; positive delta_y means up.
- ps2_clk_in, ps2_dat_in  in  1 each  raw line levels (asynchronous).
- ps2_clk_oe, ps2_dat_oe  out  1 each  1 = pull the line low, 0 = release it.
- busy  out  1  high whenever state is not IDLE.
- packet_sent  out  1  one-cycle pulse when byte 2 completes its gap.
- byte_aborted  out  1  one-cycle pulse when host inhibit kills a frame.

## Operation
- Reset values: report_ready=1, busy=0, ps2_clk_oe=0, ps2_dat_oe=0, packet_sent=0, byte_aborted=0. State goes to IDLE; byte index and bit counter go to 0.
- ps2_clk_in and ps2_dat_in each pass through a 2-flop synchroniser; all decisions use the synchronised values.
- Saturation, applied per axis at accept:
  - d > 255: 9-bit value 0_1111_1111, overflow=1.
  - d < -256: 9-bit value 1_0000_0000, overflow=1.
  - otherwise: d[8:0], overflow=0.
- Packet bytes:
  - byte0 = {Yovf, Xovf, Ysign, Xsign, 1, middle, right, left}.
  - byte1 = X[7:0].
  - byte2 = Y[7:0].
- Frame: start 0, data bits 0-7 LSB first, odd parity, stop 1. 11 bits, each one HIGH phase then one LOW phase.
- ps2_dat_oe = ~bit_value. It changes only at the first cycle of a HIGH phase.
- States:
  - IDLE: on accept, latch the packet, set byte index to 0, go to WAIT_BUS.
  - WAIT_BUS: both synchronised lines must read high for GAP_CYCLES consecutive cycles, then go to BIT_HIGH with bit 0. Any low reading restarts the count. The first entry after accept skips the wait if both lines are already high.
  - BIT_HIGH: ps2_clk_oe=0 for CLK_DIV cycles, then go to BIT_LOW.
  - BIT_LOW: ps2_clk_oe=1 for CLK_DIV cycles. Then advance to the next bit's BIT_HIGH, or after bit 10 release both lines and go to GAP.
  - GAP: lines released for GAP_CYCLES cycles. Then either advance to the next byte via BIT_HIGH, or after byte 2 pulse packet_sent and return to IDLE.
- Host inhibit: in BIT_HIGH of bits 0-9, ignore the first 3 cycles (synchroniser settling). After that, a synchronised ps2_clk_in low means inhibit:
  - release both lines, pulse byte_aborted, go to WAIT_BUS;
  - retransmit the same byte from the start bit;
  - already-sent bytes are not resent.
- Inhibit during bit 10 (stop) is ignored; the byte counts as delivered.
- Inputs are ignored while busy. Reset mid-frame releases both lines immediately (asynchronously) and discards the packet.

## Timing
- Accept at edge N; report_ready=0 from N+1. With a free bus, ps2_dat_oe=1 (start bit) also from N+1.
- One frame = 22*CLK_DIV cycles. Falling clock edges (ps2_clk_oe 0 to 1) occur at frame offsets CLK_DIV + 2k*CLK_DIV, for k = 0..10.
- Unobstructed packet: accept to packet_sent = 3*(22*CLK_DIV + GAP_CYCLES) cycles. report_ready returns high the same cycle as packet_sent.
- Data is stable for at least the whole HIGH and LOW phase around every falling edge.

## Test plan
- Basic packet (CLK_DIV=8, GAP_CYCLES=16, idle lines high): left=1, dx=+5, dy=-3. Required:
  - bytes sampled at falling edges: 0x29 (parity 0), 0x05 (parity 1), 0xFD (parity 0);
  - packet_sent exactly 3*(176+16)=576 cycles after accept.
- Saturation: dx=+300, dy=-400, no buttons. Required:
  - bytes 0xE8 (parity 1), 0xFF (parity 1), 0x00 (parity 1).
- Inhibit: during byte1 bit 4 HIGH phase, hold ps2_clk_in low 50 cycles. Required:
  - byte_aborted pulse and both oe low within 5 cycles;
  - after 16 free cycles, byte1 is resent in full and byte0 is not resent.
- Late inhibit: pull the clock low during the stop bit of byte2. Required:
  - no abort and packet_sent still issued.
- Handshake: hold report_valid high continuously with changing deltas. Required:
  - only reports presented in the cycle report_ready is high are accepted;
  - the next packet's start bit begins the cycle after the previous packet_sent.
- Reset mid-frame: assert reset in byte0 bit 3. Required:
  - both oe drop with no clock edge;
  - report_ready=1 and busy=0 after reset releases, and no packet_sent.
